// File: rtl/upct.sv
// Upper PC Table: eight shared entries holding target PC[31:11] for the BTB.
// The encode side maps a full target PC to a 3-bit entry index. It reuses a
// matching entry, or allocates the lowest free entry, or evicts the tree-PLRU
// victim. The decode side turns an index back into the stored upper PC.
module upct #(
    parameter int UPPER_PC_TABLE_ENTRIES = 8,
    parameter int UPPER_PC_WIDTH         = 21,
    localparam int LOG_UPCT_ENTRIES      = $clog2(UPPER_PC_TABLE_ENTRIES)
) (
    input  logic                        CLK,
    input  logic                        rst,
    input  logic                        read_valid,
    input  logic [LOG_UPCT_ENTRIES-1:0] read_index,
    output logic [UPPER_PC_WIDTH-1:0]   read_upper_PC,
    input  logic                        update0_valid,
    input  logic [31:0]                 update0_target_full_PC,
    output logic                        update1_valid,
    output logic                        update1_hit,
    output logic [LOG_UPCT_ENTRIES-1:0] update1_upper_PC_index
);

    localparam int E  = UPPER_PC_TABLE_ENTRIES;
    localparam int LW = LOG_UPCT_ENTRIES;
    localparam int W  = UPPER_PC_WIDTH;

    // Table state. The table is reset and searched in parallel (CAM-like),
    // so it is built from flops rather than block RAM.
    logic [W-1:0]  upper_pc_reg [E];
    logic [E-1:0]  valid_reg;
    logic [E-2:0]  plru_reg;

    // Lookup and allocation signals.
    logic [W-1:0]  tag;
    logic [E-1:0]  hit_vec;
    logic          hit;
    logic [LW-1:0] hit_idx;
    logic          free_found;
    logic [LW-1:0] free_idx;
    logic [LW-1:0] victim_idx;
    logic [LW-1:0] alloc_idx;
    logic [E-2:0]  plru_next;
    logic [LW:0]   vict_node;
    logic [LW:0]   touch_node;
    logic          touch_bit;

    // The BTB keeps PC[10:1] itself, so only the upper bits are stored here.
    assign tag = update0_target_full_PC[31:32-W];

    logic unused_low_pc;
    assign unused_low_pc = ^update0_target_full_PC[31-W:0];

    // Match the tag against every valid entry at once.
    generate
        for (genvar gi = 0; gi < E; gi++) begin : g_match
            assign hit_vec[gi] = valid_reg[gi] && (upper_pc_reg[gi] == tag);
        end
    endgenerate

    // Select the entry to use (hit, else lowest free, else PLRU victim) and
    // compute the PLRU state that results from touching it.
    always_comb begin
        hit     = |hit_vec;
        hit_idx = '0;
        for (int i = 0; i < E; i++) begin
            if (hit_vec[i]) hit_idx = LW'(i);
        end

        // Scan from the top down so that the lowest free entry wins.
        free_found = 1'b0;
        free_idx   = '0;
        for (int i = E - 1; i >= 0; i--) begin
            if (!valid_reg[i]) begin
                free_found = 1'b1;
                free_idx   = LW'(i);
            end
        end

        // Node n has children 2n+1 (lower side) and 2n+2 (higher side).
        // A bit of 0 means the LRU side is the lower one. Leaves sit at
        // E-1+index. Internal nodes always fit in LW bits.
        vict_node = '0;
        for (int l = 0; l < LW; l++) begin
            vict_node = {vict_node[LW-1:0], 1'b0} + (LW+1)'(1)
                      + (LW+1)'(plru_reg[vict_node[LW-1:0]]);
        end
        victim_idx = LW'(vict_node - (LW+1)'(E - 1));

        if (hit)             alloc_idx = hit_idx;
        else if (free_found) alloc_idx = free_idx;
        else                 alloc_idx = victim_idx;

        // Each node on the path is pointed away from the touched index.
        plru_next  = plru_reg;
        touch_node = '0;
        touch_bit  = 1'b0;
        for (int l = 0; l < LW; l++) begin
            touch_bit = alloc_idx[LW-1-l];
            plru_next[touch_node[LW-1:0]] = ~touch_bit;
            touch_node = {touch_node[LW-1:0], 1'b0} + (LW+1)'(1)
                       + (LW+1)'(touch_bit);
        end
    end

    // Register the read data and the update result, and commit allocations.
    // A read in the same cycle as a write returns the old value.
    always_ff @(posedge CLK) begin
        if (rst) begin
            valid_reg              <= '0;
            plru_reg               <= '0;
            read_upper_PC          <= '0;
            update1_valid          <= 1'b0;
            update1_hit            <= 1'b0;
            update1_upper_PC_index <= '0;
            for (int i = 0; i < E; i++) begin
                upper_pc_reg[i] <= '0;
            end
        end else begin
            if (read_valid) begin
                read_upper_PC <= upper_pc_reg[read_index];
            end
            update1_valid <= update0_valid;
            if (update0_valid) begin
                update1_hit            <= hit;
                update1_upper_PC_index <= alloc_idx;
                plru_reg               <= plru_next;
                if (!hit) begin
                    upper_pc_reg[alloc_idx] <= tag;
                    valid_reg[alloc_idx]    <= 1'b1;
                end
            end
        end
    end

endmodule
